mem_port_arbiter: RTL and testbench

// - Shares one single-port, 1-cycle-read-latency unified SRAM between the IF-stage fetch port and the MEM-stage load/store port.
// - Enables the core to run load/store tests from one memory image.
// - Sits in cpu_top between the pipeline and the memory macro.
// - Grants combinationally, steers the read-return data to the owner one cycle later, and raises stall_if while fetch is denied.
//

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one single-port 1-cycle-latency SRAM
//
// Optional build macro: MEM_ARB_STARVE_GUARD_EN
//   defined   -> fetch is forced to win a contested cycle after STARVE_MAX
//                consecutive denied fetch cycles
//   undefined -> strict data-over-fetch priority, no starvation counter

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  // IF-stage fetch port (read only)
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                stall_if,

  // MEM-stage load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  // SRAM macro side
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  // A non-positive starvation limit would make the guard meaningless.
  if (STARVE_MAX < 1) begin : g_starve_max_chk
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  // Who owns the read data coming back from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_D_RD  = 2'd2
  } owner_t;

  owner_t owner;
  owner_t owner_next;

  // High when fetch must win a cycle in which both ports request.
  logic fetch_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved    = (starve_cnt == CNT_W'(STARVE_MAX));
  assign fetch_wins = starved;

  // Count consecutive cycles in which fetch asks and is refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`else

  assign fetch_wins = 1'b0;

`endif

  // Owner state register; reset discards any read that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Next owner follows this cycle's grant; stores return nothing.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_IF_RD;
    end else if (d_gnt && !d_we) begin
      owner_next = OWN_D_RD;
    end
  end

  // Grants, memory-side mux and read-return steering.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    stall_if  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;

    if (!rst) begin
      // Data side holds the older instruction, so it normally wins.
      if (d_req && !(if_req && fetch_wins)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end

      stall_if = if_req && !if_gnt;
      mem_en   = if_gnt || d_gnt;

      if (if_gnt) begin
        mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
      end else if (d_gnt) begin
        mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = d_wdata;
        mem_we    = d_we ? d_be : {BE_W{1'b0}};
      end

      if_rvalid = (owner == OWN_IF_RD);
      d_rvalid  = (owner == OWN_D_RD);

      if (if_rvalid) begin
        if_rdata = mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        stall_if;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;
  logic exp_if;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .stall_if  (stall_if),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_be      = 4'h0;
    d_addr    = 32'h0000_3000;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;

    // Reset held two cycles with both ports requesting: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst_if_gnt_%0d", i),    if_gnt,    0);
      check($sformatf("rst_d_gnt_%0d", i),     d_gnt,     0);
      check($sformatf("rst_mem_en_%0d", i),    mem_en,    0);
      check($sformatf("rst_if_rvalid_%0d", i), if_rvalid, 0);
      check($sformatf("rst_d_rvalid_%0d", i),  d_rvalid,  0);
      check($sformatf("rst_stall_%0d", i),     stall_if,  0);
    end

    // First cycle out of reset: data wins.
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rel_d_gnt",    d_gnt,    1);
    check("rel_if_gnt",   if_gnt,   0);
    check("rel_stall",    stall_if, 1);
    check("rel_mem_en",   mem_en,   1);
    check("rel_mem_addr", mem_addr, 32'h0000_3000);

    step();
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    check("rel_d_rvalid",  d_rvalid,  1);
    check("rel_d_rdata",   d_rdata,   32'hAAAA_5555);
    check("rel_if_rvalid", if_rvalid, 0);
    check("rel_if_rdata",  if_rdata,  0);

    // Fetch only.
    step();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0104;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("f_if_gnt",   if_gnt,   1);
    check("f_mem_addr", mem_addr, 32'h0000_0104);
    check("f_mem_we",   mem_we,   0);
    check("f_mem_en",   mem_en,   1);
    check("f_stall",    stall_if, 0);

    step();
    if_req    = 1'b0;
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    check("f_if_rvalid", if_rvalid, 1);
    check("f_if_rdata",  if_rdata,  32'h0000_0013);
    check("f_d_rvalid",  d_rvalid,  0);
    check("f_d_rdata",   d_rdata,   0);

    // Contention: load beats fetch, byte enables ignored on a load.
    step();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0108;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_be      = 4'hF;
    d_addr    = 32'h0000_2000;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("c_d_gnt",    d_gnt,    1);
    check("c_if_gnt",   if_gnt,   0);
    check("c_stall",    stall_if, 1);
    check("c_mem_addr", mem_addr, 32'h0000_2000);
    check("c_mem_we",   mem_we,   0);

    // Back-to-back: fetch granted in the same cycle as the load return.
    step();
    d_req     = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("c_if_gnt2",   if_gnt,   1);
    check("c_d_rvalid",  d_rvalid, 1);
    check("c_d_rdata",   d_rdata,  32'hDEAD_BEEF);
    check("c_if_rdata0", if_rdata, 0);
    check("c_mem_addr2", mem_addr, 32'h0000_0108);

    step();
    if_req    = 1'b0;
    mem_rdata = 32'h1122_3344;
    @(negedge clk);
    check("c_if_rvalid", if_rvalid, 1);
    check("c_if_rdata",  if_rdata,  32'h1122_3344);
    check("c_d_rvalid2", d_rvalid,  0);

    // Store with partial byte enables and an unaligned address.
    step();
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_be      = 4'b0011;
    d_addr    = 32'h0000_2002;
    d_wdata   = 32'h0000_1234;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("s_d_gnt",     d_gnt,     1);
    check("s_mem_we",    mem_we,    4'b0011);
    check("s_mem_addr",  mem_addr,  32'h0000_2000);
    check("s_mem_wdata", mem_wdata, 32'h0000_1234);

    step();
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("s_d_rvalid",  d_rvalid,  0);
    check("s_d_rdata",   d_rdata,   0);
    check("s_if_rvalid", if_rvalid, 0);
    check("idle_mem_en", mem_en,    0);
    check("idle_addr",   mem_addr,  0);
    check("idle_wdata",  mem_wdata, 0);

    // Both ports held for 8 cycles.
    step();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0200;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_3000;
    mem_rdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (i == 5);
`else
      exp_if = 1'b0;
`endif
      check($sformatf("st_if_gnt_c%0d", i), if_gnt, exp_if);
      check($sformatf("st_d_gnt_c%0d", i),  d_gnt,  !exp_if);
      if (i < 8) step();
    end

    step();
    d_req = 1'b0;
    @(negedge clk);
    check("st_if_gnt_after", if_gnt, 1);

    // Reset arriving while a load is in flight.
    step();
    if_req = 1'b0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0040;
    @(negedge clk);
    check("rm_d_gnt", d_gnt, 1);

    step();
    d_req     = 1'b0;
    rst       = 1'b1;
    if_req    = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("rm_d_rvalid1", d_rvalid, 0);
    check("rm_d_rdata1",  d_rdata,  0);
    check("rm_if_gnt",    if_gnt,   0);
    check("rm_stall",     stall_if, 0);
    check("rm_mem_en",    mem_en,   0);

    step();
    rst    = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check("rm_d_rvalid2",  d_rvalid,  0);
    check("rm_if_rvalid2", if_rvalid, 0);

    step();
    @(negedge clk);
    check("rm_d_rvalid3", d_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
